// File: rtl/timer_pkg.sv
// Shared general_timer types: PWM measurement state enum and default counter width.
// No logic; latency and backpressure not applicable.
package timer_pkg;

    localparam int PWM_MEAS_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_meas_state_e;

endpackage

// File: rtl/pwm_meas_sync.sv
// PWM input conditioning: 2-flop sync, optional glitch filter (PWM_MEAS_FILTER_EN), registered level, edge detect.
// Pin-to-edge latency 3 cycles (3+FILT_LEN filtered); free-running, no backpressure.
module pwm_meas_sync #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_det_o,
    output logic fall_det_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_q, level_d;
    logic prev_q,  prev_d;

`ifdef PWM_MEAS_FILTER_EN
    localparam int FCNT_W = $clog2(FILT_LEN + 1);

    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // A new level is accepted only after FILT_LEN consecutive agreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FCNT_W'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb level_d = filt_q;
`else
    always_comb level_d = sync2_q;
`endif

    always_comb begin
        sync1_d = pwm_i;
        sync2_d = sync1_q;
        prev_d  = level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
        end
    end

    assign level_o    = level_q;
    assign rise_det_o = level_q & ~prev_q;
    assign fall_det_o = ~level_q & prev_q;

endmodule

// File: rtl/pwm_meas.sv
// PWM period/high-time measurement with sticky ovf/timeout/irq; glitch filter via PWM_MEAS_FILTER_EN.
// meas_stb one cycle after the terminating rise_det; free-running input, no backpressure.
module pwm_meas
    import timer_pkg::*;
#(
    parameter int CNT_W    = PWM_MEAS_CNT_W,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_i,
    input  logic [CNT_W-1:0] timeout_val,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] period_val,
    output logic [CNT_W-1:0] high_val,
    output logic             meas_stb,
    output logic             ovf,
    output logic             timeout,
    output logic             busy,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pwm_meas_state_e  state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] high_hold_q, high_hold_d;
    logic [CNT_W-1:0] period_val_q, period_val_d;
    logic [CNT_W-1:0] high_val_q, high_val_d;
    logic             meas_stb_q, meas_stb_d;
    logic             ovf_q, ovf_d;
    logic             timeout_q, timeout_d;
    logic             irq_q, irq_d;

    logic level, rise_det, fall_det;
    logic sat_hit, to_hit, ovf_ev, to_ev;

    pwm_meas_sync #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .pwm_i      (pwm_i),
        .level_o    (level),
        .rise_det_o (rise_det),
        .fall_det_o (fall_det)
    );

    // per_cnt never trails high_cnt, so it alone guards saturation.
    assign sat_hit = (per_cnt_q == CNT_MAX);
    assign to_hit  = (timeout_val != '0) && (per_cnt_q == timeout_val);

    always_comb begin
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        high_cnt_d   = high_cnt_q;
        high_hold_d  = high_hold_q;
        period_val_d = period_val_q;
        high_val_d   = high_val_q;
        meas_stb_d   = 1'b0;
        ovf_ev       = 1'b0;
        to_ev        = 1'b0;

        unique case (state_q)
            IDLE: begin
                per_cnt_d  = '0;
                high_cnt_d = '0;
                if (en) state_d = ARM;
            end
            ARM: begin
                per_cnt_d  = '0;
                high_cnt_d = '0;
                if (rise_det && level) state_d = HIGH;
            end
            HIGH: begin
                if (sat_hit) begin
                    ovf_ev  = 1'b1;
                    state_d = ARM;
                end else if (to_hit) begin
                    to_ev   = 1'b1;
                    state_d = ARM;
                end else begin
                    per_cnt_d  = per_cnt_q + 1'b1;
                    high_cnt_d = high_cnt_q + 1'b1;
                    if (fall_det) begin
                        high_hold_d = high_cnt_q;
                        state_d     = LOW;
                    end
                end
            end
            LOW: begin
                if (sat_hit) begin
                    ovf_ev  = 1'b1;
                    state_d = ARM;
                end else if (to_hit) begin
                    to_ev   = 1'b1;
                    state_d = ARM;
                end else if (rise_det) begin
                    period_val_d = per_cnt_q + 1'b1;
                    high_val_d   = high_hold_q + 1'b1;
                    meas_stb_d   = 1'b1;
                    per_cnt_d    = '0;
                    high_cnt_d   = '0;
                    state_d      = HIGH;
                end else begin
                    per_cnt_d = per_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d      = IDLE;
            per_cnt_d    = '0;
            high_cnt_d   = '0;
            period_val_d = period_val_q;
            high_val_d   = high_val_q;
            meas_stb_d   = 1'b0;
            ovf_ev       = 1'b0;
            to_ev        = 1'b0;
        end

        // The visible strobe cycle also counts as a set, so a clear issued on it loses.
        ovf_d     = ovf_ev | (ovf_q & ~irq_clr);
        timeout_d = to_ev | (timeout_q & ~irq_clr);
        irq_d     = meas_stb_d | meas_stb_q | ovf_ev | to_ev | (irq_q & ~irq_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            per_cnt_q    <= '0;
            high_cnt_q   <= '0;
            high_hold_q  <= '0;
            period_val_q <= '0;
            high_val_q   <= '0;
            meas_stb_q   <= 1'b0;
            ovf_q        <= 1'b0;
            timeout_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            high_cnt_q   <= high_cnt_d;
            high_hold_q  <= high_hold_d;
            period_val_q <= period_val_d;
            high_val_q   <= high_val_d;
            meas_stb_q   <= meas_stb_d;
            ovf_q        <= ovf_d;
            timeout_q    <= timeout_d;
            irq_q        <= irq_d;
        end
    end

    assign period_val = period_val_q;
    assign high_val   = high_val_q;
    assign meas_stb   = meas_stb_q;
    assign ovf        = ovf_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != IDLE);
    assign irq        = irq_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: waveform table plus hand sequences for timeout, en drop, clear and overflow.
module tb_pwm_meas;
    import timer_pkg::*;

`ifdef PWM_MEAS_FILTER_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 32-bit counters
    logic        rst, en, pwm_i, irq_clr;
    logic [31:0] timeout_val, period_val, high_val;
    logic        meas_stb, ovf, timeout, busy, irq;

    // DUT B: 8-bit counters for the overflow case
    logic       en_b, pwm_b, irq_clr_b;
    logic [7:0] timeout_val_b, period_val_b, high_val_b;
    logic       meas_stb_b, ovf_b, timeout_b, busy_b, irq_b;

    pwm_meas u_dut (
        .clk(clk), .rst(rst), .en(en), .pwm_i(pwm_i), .timeout_val(timeout_val),
        .irq_clr(irq_clr), .period_val(period_val), .high_val(high_val),
        .meas_stb(meas_stb), .ovf(ovf), .timeout(timeout), .busy(busy), .irq(irq)
    );

    pwm_meas #(.CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .pwm_i(pwm_b), .timeout_val(timeout_val_b),
        .irq_clr(irq_clr_b), .period_val(period_val_b), .high_val(high_val_b),
        .meas_stb(meas_stb_b), .ovf(ovf_b), .timeout(timeout_b), .busy(busy_b), .irq(irq_b)
    );

    typedef struct {
        int          hi;
        int          lo;
        bit          stb;
        logic [31:0] per;
        logic [31:0] hw;
    } vec_t;

    typedef struct {
        logic [31:0] per;
        logic [31:0] hw;
    } res_t;

    vec_t vecs[8];
    res_t got_q[$];
    int   checks = 0;
    int   errors = 0;
    int   clr_stb_idx = -1;
    int   clr_req = 0;
    int   clr_done = 0;
    int   stb_cnt_b = 0;
    bit   chk_next = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Main stimulus acts at posedge+2; this process samples at posedge+1 and owns irq_clr.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        irq_clr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            irq_clr = 1'b0;
            if (chk_next) begin
                chk("irq_held_after_clr_on_stb", 32'(irq), 32'd1);
                chk_next = 1'b0;
            end
            if (meas_stb) begin
                chk("irq_with_stb", 32'(irq), 32'd1);
                if (got_q.size() == clr_stb_idx) begin
                    irq_clr  = 1'b1;
                    chk_next = 1'b1;
                end
                got_q.push_back('{period_val, high_val});
            end else if (clr_req != clr_done) begin
                irq_clr = 1'b1;
                clr_done++;
            end
            if (meas_stb_b) stb_cnt_b++;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        int exp_cnt;
        int k;
        int n;
        int base;

        vecs[0] = '{10, 10, 1'b1, 32'd20, 32'd10};
        vecs[1] = '{10, 10, 1'b1, 32'd20, 32'd10};
        vecs[2] = '{10, 10, 1'b1, 32'd20, 32'd10};
        vecs[3] = '{5,  15, 1'b1, 32'd20, 32'd5};
        vecs[4] = '{5,  15, 1'b1, 32'd20, 32'd5};
`ifdef PWM_MEAS_FILTER_EN
        vecs[5] = '{10, 4,  1'b0, 32'd0,  32'd0};
        vecs[6] = '{2,  4,  1'b1, 32'd20, 32'd10};
`else
        vecs[5] = '{10, 4,  1'b1, 32'd14, 32'd10};
        vecs[6] = '{2,  4,  1'b1, 32'd6,  32'd2};
`endif
        vecs[7] = '{10, 10, 1'b1, 32'd20, 32'd10};

        rst = 1'b1; en = 1'b0; pwm_i = 1'b0; timeout_val = 32'd50;
        en_b = 1'b0; pwm_b = 1'b0; irq_clr_b = 1'b0; timeout_val_b = 8'd0;
        repeat (3) tick();
        chk("rst_period_val", period_val, 32'd0);
        chk("rst_high_val",   high_val,   32'd0);
        chk("rst_meas_stb",   32'(meas_stb), 32'd0);
        chk("rst_ovf",        32'(ovf),     32'd0);
        chk("rst_timeout",    32'(timeout), 32'd0);
        chk("rst_busy",       32'(busy),    32'd0);
        chk("rst_irq",        32'(irq),     32'd0);

        rst = 1'b0;
        tick();
        chk("busy_en_low", 32'(busy), 32'd0);
        en = 1'b1; en_b = 1'b1;
        tick();
        chk("busy_after_en", 32'(busy), 32'd1);
        repeat (3) tick();

        // Table: each entry is one pwm cycle; its strobe appears after the next rise.
        clr_stb_idx = 3;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            pwm_i = 1'b1;
            repeat (vecs[i].hi) tick();
            pwm_i = 1'b0;
            repeat (vecs[i].lo) tick();
            if (vecs[i].stb) exp_cnt++;
        end

        // Final rise terminates the last entry, then the line sticks high.
        pwm_i = 1'b1;
        n = 0;
        while (!timeout && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_latency", 32'(n), 32'(LAT + 52));
        chk("timeout_flag", 32'(timeout), 32'd1);
        chk("state_after_timeout", 32'(u_dut.state_q), 32'(ARM));
        chk("busy_after_timeout", 32'(busy), 32'd1);

        chk("stb_count", 32'(got_q.size()), 32'(exp_cnt));
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].stb) begin
                if (k < got_q.size()) begin
                    chk($sformatf("vec%0d_period", i), got_q[k].per, vecs[i].per);
                    chk($sformatf("vec%0d_high", i),   got_q[k].hw,  vecs[i].hw);
                end
                k++;
            end
        end
        chk("period_after_timeout", period_val, 32'd20);
        chk("high_after_timeout",   high_val,   32'd10);

        clr_req++;
        repeat (3) tick();
        chk("irq_cleared",     32'(irq),     32'd0);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        chk("ovf_never_set",   32'(ovf),     32'd0);

        // en dropped mid-HIGH, then re-raised with the line already high.
        pwm_i = 1'b0;
        repeat (10) tick();
        pwm_i = 1'b1;
        repeat (6) tick();
        chk("state_high_before_drop", 32'(u_dut.state_q), 32'(HIGH));
        base = got_q.size();
        en = 1'b0;
        tick();
        chk("busy_after_en_drop",   32'(busy), 32'd0);
        chk("period_kept_en_drop",  period_val, 32'd20);
        chk("high_kept_en_drop",    high_val,   32'd10);
        en = 1'b1;
        repeat (6) tick();
        pwm_i = 1'b0;
        repeat (10) tick();
        pwm_i = 1'b1;
        repeat (12) tick();
        pwm_i = 1'b0;
        repeat (8) tick();
        chk("no_stb_after_first_rise", 32'(got_q.size()), 32'(base));
        pwm_i = 1'b1;
        repeat (8) tick();
        chk("reen_stb_count", 32'(got_q.size()), 32'(base + 1));
        if (got_q.size() > base) begin
            chk("reen_period", got_q[base].per, 32'd20);
            chk("reen_high",   got_q[base].hw,  32'd12);
        end

        // Overflow on the 8-bit instance after one good 20/10 measurement.
        pwm_b = 1'b1;
        repeat (10) tick();
        pwm_b = 1'b0;
        repeat (10) tick();
        pwm_b = 1'b1;
        repeat (5) tick();
        chk("b_first_stb_count", 32'(stb_cnt_b), 32'd1);
        chk("b_first_period",    32'(period_val_b), 32'd20);
        chk("b_ovf_before",      32'(ovf_b), 32'd0);
        repeat (145) tick();
        pwm_b = 1'b0;
        repeat (150) tick();
        pwm_b = 1'b1;
        repeat (10) tick();
        chk("b_ovf_set",         32'(ovf_b), 32'd1);
        chk("b_no_stb_on_ovf",   32'(stb_cnt_b), 32'd1);
        chk("b_period_kept",     32'(period_val_b), 32'd20);
        chk("b_high_kept",       32'(high_val_b), 32'd10);
        chk("b_irq_set",         32'(irq_b), 32'd1);
        chk("b_timeout_clear",   32'(timeout_b), 32'd0);
        chk("b_busy",            32'(busy_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
